mem_addr_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 45 ++++
 rtl/mem_addr_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_addr_arbiter.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-address arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StDone
   } arb_state_e;

   localparam int unsigned MODE_FIXED = 0;
   localparam int unsigned MODE_RR    = 1;
   localparam int unsigned CNT_W      = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational winner select: fixed priority (lowest index) or round-robin
// scanning upward from rr_ptr_i + 1 with wrap.
module rr_pick
   import mem_arb_pkg::*;
#(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned IDX_W  = 1
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [IDX_W-1:0]  rr_ptr_i,
   input  logic              mode_i,
   output logic [NUM_CH-1:0] gnt_o,
   output logic [IDX_W-1:0]  idx_o,
   output logic              valid_o
);

   // Scan candidates in priority order and take the first requester.
   always_comb begin
      int unsigned cand;
      logic        found;
      cand    = 0;
      found   = 1'b0;
      gnt_o   = '0;
      idx_o   = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (mode_i) begin
            // rr_ptr never exceeds NUM_CH-1, so one subtraction wraps it.
            cand = 32'(rr_ptr_i) + i + 1;
            if (cand >= NUM_CH) begin
               cand = cand - NUM_CH;
            end
         end else begin
            cand = i;
         end
         if (!found && req_i[cand[IDX_W-1:0]]) begin
            found = 1'b1;
            idx_o = cand[IDX_W-1:0];
            gnt_o = '0;
            gnt_o[cand[IDX_W-1:0]] = 1'b1;
         end
      end
      valid_o = found;
   end

endmodule

// File: rtl/mem_addr_arbiter.sv
// Single-port RAM address arbiter: grants one channel at a time, holds its
// address for the whole access, pulses done, and parks on the fetch address.
module mem_addr_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned NUM_CH     = 2,
   parameter int unsigned ACCESS_LAT = 1,
   parameter int unsigned MODE       = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH-1:0]        req,
   input  logic [NUM_CH*ADDR_W-1:0] addr_in,
   input  logic [NUM_CH-1:0]        we_in,
   output logic [NUM_CH-1:0]        grant,
   output logic [NUM_CH-1:0]        done,
   output logic [ADDR_W-1:0]        addressOut,
   output logic                     we_out,
   output logic                     busy
);

   localparam int unsigned IDX_W = $clog2(NUM_CH);
   localparam logic [CNT_W-1:0] CntLoad = CNT_W'(ACCESS_LAT - 1);
   localparam logic [IDX_W-1:0] PtrInit = IDX_W'(NUM_CH - 1);

   arb_state_e        state_q, state_d;
   logic [NUM_CH-1:0] grant_q, grant_d;
   logic [NUM_CH-1:0] done_q, done_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic              busy_q, busy_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]  win_q, win_d;

   logic [NUM_CH-1:0] pick_gnt;
   logic [IDX_W-1:0]  pick_idx;
   logic              pick_valid;
   logic [ADDR_W-1:0] sel_addr;
   logic              sel_we;

   rr_pick #(
      .NUM_CH (NUM_CH),
      .IDX_W  (IDX_W)
   ) u_pick (
      .req_i    (req),
      .rr_ptr_i (rr_ptr_q),
      .mode_i   (MODE == MODE_RR),
      .gnt_o    (pick_gnt),
      .idx_o    (pick_idx),
      .valid_o  (pick_valid)
   );

   // Mux the winning channel's address and write enable.
   always_comb begin
      sel_addr = addr_in[ADDR_W-1:0];
      sel_we   = 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (pick_gnt[i]) begin
            sel_addr = addr_in[i*ADDR_W +: ADDR_W];
            sel_we   = we_in[i];
         end
      end
   end

   // Next-state and output-register logic for the IDLE/BUSY/DONE sequence.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      done_d   = '0;
      addr_d   = addr_q;
      we_d     = we_q;
      busy_d   = busy_q;
      cnt_d    = cnt_q;
      rr_ptr_d = rr_ptr_q;
      win_d    = win_q;
      unique case (state_q)
         StIdle: begin
            if (pick_valid) begin
               addr_d  = sel_addr;
               we_d    = sel_we;
               grant_d = pick_gnt;
               win_d   = pick_idx;
               cnt_d   = CntLoad;
               busy_d  = 1'b1;
               state_d = StBusy;
            end else begin
               // Park on the fetch address while nobody asks.
               addr_d  = addr_in[ADDR_W-1:0];
               we_d    = 1'b0;
               grant_d = '0;
               busy_d  = 1'b0;
            end
         end
         StBusy: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               done_d  = grant_q;
               grant_d = '0;
               busy_d  = 1'b0;
               state_d = StDone;
            end
         end
         StDone: begin
            // Bubble cycle so the finished requester can drop req.
            if (MODE == MODE_RR) begin
               rr_ptr_d = win_q;
            end
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers, synchronous reset.
   always_ff @(negedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         grant_q  <= '0;
         done_q   <= '0;
         addr_q   <= '0;
         we_q     <= 1'b0;
         busy_q   <= 1'b0;
         cnt_q    <= '0;
         rr_ptr_q <= PtrInit;
         win_q    <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         done_q   <= done_d;
         addr_q   <= addr_d;
         we_q     <= we_d;
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
         rr_ptr_q <= rr_ptr_d;
         win_q    <= win_d;
      end
   end

   assign grant      = grant_q;
   assign done       = done_q;
   assign addressOut = addr_q;
   assign we_out     = we_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_mem_addr_arbiter.sv
// Bench for mem_addr_arbiter: three instances (fixed LAT3, round-robin LAT3,
// round-robin LAT1) share one stimulus and are compared to a timeline model.
module tb_mem_addr_arbiter;

   localparam int unsigned AW = 16;
   localparam int unsigned NC = 4;
   localparam int unsigned ND = 3;

   logic             clk;
   logic             rst;
   logic [NC-1:0]    req;
   logic [NC*AW-1:0] addr_in;
   logic [NC-1:0]    we_in;

   logic [NC-1:0] grant_o [ND];
   logic [NC-1:0] done_o  [ND];
   logic [AW-1:0] addr_o  [ND];
   logic          we_o    [ND];
   logic          busy_o  [ND];

   int total;
   int bad;

   // Model: each access is remembered by its grant edge and winner.
   int            edge_n;
   bit            m_active [ND];
   int            m_start  [ND];
   int            m_win    [ND];
   int            m_ptr    [ND];
   logic [AW-1:0] m_addr   [ND];
   logic          m_we     [ND];

   mem_addr_arbiter #(.ADDR_W(AW), .NUM_CH(NC), .ACCESS_LAT(3), .MODE(0)) u_fix3 (
      .clk(clk), .rst(rst), .req(req), .addr_in(addr_in), .we_in(we_in),
      .grant(grant_o[0]), .done(done_o[0]), .addressOut(addr_o[0]),
      .we_out(we_o[0]), .busy(busy_o[0])
   );

   mem_addr_arbiter #(.ADDR_W(AW), .NUM_CH(NC), .ACCESS_LAT(3), .MODE(1)) u_rr3 (
      .clk(clk), .rst(rst), .req(req), .addr_in(addr_in), .we_in(we_in),
      .grant(grant_o[1]), .done(done_o[1]), .addressOut(addr_o[1]),
      .we_out(we_o[1]), .busy(busy_o[1])
   );

   mem_addr_arbiter #(.ADDR_W(AW), .NUM_CH(NC), .ACCESS_LAT(1), .MODE(1)) u_rr1 (
      .clk(clk), .rst(rst), .req(req), .addr_in(addr_in), .we_in(we_in),
      .grant(grant_o[2]), .done(done_o[2]), .addressOut(addr_o[2]),
      .we_out(we_o[2]), .busy(busy_o[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   function automatic int lat_of(int k);
      return (k == 2) ? 1 : 3;
   endfunction

   function automatic bit rr_of(int k);
      return (k != 0);
   endfunction

   function automatic int pick(int k);
      for (int j = 0; j < int'(NC); j++) begin
         int c;
         c = rr_of(k) ? (m_ptr[k] + 1 + j) % NC : j;
         if (req[c]) return c;
      end
      return -1;
   endfunction

   function automatic logic [NC-1:0] exp_grant(int k);
      if (m_active[k] && (edge_n - m_start[k]) < lat_of(k)) return NC'(1) << m_win[k];
      return '0;
   endfunction

   function automatic logic [NC-1:0] exp_done(int k);
      if (m_active[k] && (edge_n - m_start[k]) == lat_of(k)) return NC'(1) << m_win[k];
      return '0;
   endfunction

   function automatic logic exp_busy(int k);
      return m_active[k] && (edge_n - m_start[k]) < lat_of(k);
   endfunction

   function automatic int onehot_idx(logic [NC-1:0] v);
      for (int j = 0; j < int'(NC); j++) if (v[j]) return j;
      return -1;
   endfunction

   // Advance the model by one falling edge using the inputs seen at that edge.
   task automatic model_edge();
      edge_n++;
      for (int k = 0; k < int'(ND); k++) begin
         if (rst) begin
            m_active[k] = 1'b0;
            m_ptr[k]    = NC - 1;
            m_addr[k]   = '0;
            m_we[k]     = 1'b0;
         end else if (m_active[k]) begin
            if (edge_n - m_start[k] == lat_of(k) + 1) begin
               m_active[k] = 1'b0;
               if (rr_of(k)) m_ptr[k] = m_win[k];
            end
         end else if (req != '0) begin
            m_win[k]    = pick(k);
            m_start[k]  = edge_n;
            m_active[k] = 1'b1;
            m_addr[k]   = addr_in[m_win[k]*AW +: AW];
            m_we[k]     = we_in[m_win[k]];
         end else begin
            m_addr[k] = addr_in[AW-1:0];
            m_we[k]   = 1'b0;
         end
      end
   endtask

   // One clock: DUT and model step on the falling edge, sampling on the rising one.
   task automatic tick();
      @(negedge clk);
      model_edge();
      @(posedge clk);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      req     = '1;
      addr_in = {$urandom, $urandom};
      we_in   = '1;
      tick();
      tick();
      for (int k = 0; k < int'(ND); k++) begin
         total++;
         if ({grant_o[k], done_o[k], addr_o[k], we_o[k], busy_o[k]} !== '0) begin
            bad++;
            $display("FAIL reset_values dut%0d: grant=%b done=%b addr=%h we=%b busy=%b, want all 0",
                     k, grant_o[k], done_o[k], addr_o[k], we_o[k], busy_o[k]);
         end
      end
      rst = 1'b0;
      tick();
      for (int k = 0; k < int'(ND); k++) begin
         total++;
         if (grant_o[k] !== 4'b0001 || busy_o[k] !== 1'b1) begin
            bad++;
            $display("FAIL reset_first_grant dut%0d: grant=%b busy=%b, want grant=0001 busy=1",
                     k, grant_o[k], busy_o[k]);
         end
      end
   endtask

   task automatic test_idle_park();
      apply_reset();
      req   = '0;
      we_in = '1;
      addr_in = {$urandom, $urandom};
      addr_in[AW-1:0] = 16'h0040;
      tick();
      for (int k = 0; k < int'(ND); k++) begin
         total++;
         if (addr_o[k] !== 16'h0040 || we_o[k] !== 1'b0 || grant_o[k] !== '0) begin
            bad++;
            $display("FAIL park_0040 dut%0d: addr=%h we=%b grant=%b, want addr=0040 we=0 grant=0",
                     k, addr_o[k], we_o[k], grant_o[k]);
         end
      end
      addr_in[AW-1:0] = 16'h0044;
      tick();
      for (int k = 0; k < int'(ND); k++) begin
         total++;
         if (addr_o[k] !== 16'h0044 || we_o[k] !== 1'b0) begin
            bad++;
            $display("FAIL park_0044 dut%0d: addr=%h we=%b, want addr=0044 we=0",
                     k, addr_o[k], we_o[k]);
         end
      end
   endtask

   task automatic test_single_access();
      int first_done;
      int n_done;
      apply_reset();
      first_done = -1;
      n_done     = 0;
      addr_in    = {$urandom, $urandom};
      addr_in[1*AW +: AW] = 16'h1234;
      we_in      = 4'b0010;
      req        = 4'b0010;
      tick();
      total++;
      if (grant_o[0] !== 4'b0010 || addr_o[0] !== 16'h1234 || we_o[0] !== 1'b1) begin
         bad++;
         $display("FAIL single_grant: grant=%b addr=%h we=%b, want grant=0010 addr=1234 we=1",
                  grant_o[0], addr_o[0], we_o[0]);
      end
      addr_in[1*AW +: AW] = 16'hbeef;
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (done_o[0] != '0) begin
            n_done++;
            if (first_done < 0) first_done = c;
            req = '0;
         end
         for (int k = 0; k < int'(ND); k++) begin
            total++;
            if ({grant_o[k], done_o[k], addr_o[k], we_o[k], busy_o[k]} !==
                {exp_grant(k), exp_done(k), m_addr[k], m_we[k], exp_busy(k)}) begin
               bad++;
               $display("FAIL single_cycle dut%0d c%0d: grant=%b done=%b addr=%h we=%b busy=%b, want %b %b %h %b %b",
                        k, c, grant_o[k], done_o[k], addr_o[k], we_o[k], busy_o[k],
                        exp_grant(k), exp_done(k), m_addr[k], m_we[k], exp_busy(k));
            end
         end
      end
      total++;
      if (first_done != 3 || n_done != 1) begin
         bad++;
         $display("FAIL single_done_timing: first=%0d count=%0d, want first=3 count=1",
                  first_done, n_done);
      end
   endtask

   task automatic test_contention();
      int seq0[$];
      int seq1[$];
      int tim1[$];
      apply_reset();
      req     = '1;
      addr_in = {$urandom, $urandom};
      we_in   = NC'($urandom);
      for (int c = 0; c < 30; c++) begin
         tick();
         if (done_o[0] != '0) seq0.push_back(onehot_idx(done_o[0]));
         if (done_o[1] != '0) begin
            seq1.push_back(onehot_idx(done_o[1]));
            tim1.push_back(c);
         end
         for (int k = 0; k < int'(ND); k++) begin
            total++;
            if ({grant_o[k], done_o[k], addr_o[k], we_o[k], busy_o[k]} !==
                {exp_grant(k), exp_done(k), m_addr[k], m_we[k], exp_busy(k)}) begin
               bad++;
               $display("FAIL contention_cycle dut%0d c%0d: grant=%b done=%b addr=%h we=%b busy=%b, want %b %b %h %b %b",
                        k, c, grant_o[k], done_o[k], addr_o[k], we_o[k], busy_o[k],
                        exp_grant(k), exp_done(k), m_addr[k], m_we[k], exp_busy(k));
            end
         end
      end
      total++;
      if (seq0.size() < 3 || seq1.size() < 5) begin
         bad++;
         $display("FAIL contention_count: fixed=%0d rr=%0d accesses, want >=3 and >=5",
                  seq0.size(), seq1.size());
      end else begin
         for (int j = 0; j < 3; j++) begin
            total++;
            if (seq0[j] != 0) begin
               bad++;
               $display("FAIL contention_fixed[%0d]: ch=%0d, want 0", j, seq0[j]);
            end
         end
         for (int j = 0; j < 5; j++) begin
            total++;
            if (seq1[j] != j % 4) begin
               bad++;
               $display("FAIL contention_rr[%0d]: ch=%0d, want %0d", j, seq1[j], j % 4);
            end
         end
         for (int j = 0; j < 4; j++) begin
            total++;
            if (tim1[j+1] - tim1[j] != 5) begin
               bad++;
               $display("FAIL contention_spacing[%0d]: gap=%0d, want 5", j, tim1[j+1] - tim1[j]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_access();
      apply_reset();
      addr_in = {$urandom, $urandom};
      we_in   = '1;
      req     = 4'b0100;
      tick();
      tick();
      rst = 1'b1;
      tick();
      for (int k = 0; k < int'(ND); k++) begin
         total++;
         if ({grant_o[k], done_o[k], addr_o[k], we_o[k], busy_o[k]} !== '0) begin
            bad++;
            $display("FAIL midreset_values dut%0d: grant=%b done=%b addr=%h we=%b busy=%b, want all 0",
                     k, grant_o[k], done_o[k], addr_o[k], we_o[k], busy_o[k]);
         end
      end
      rst = 1'b0;
      req = 4'b1000;
      tick();
      for (int k = 0; k < int'(ND); k++) begin
         total++;
         if (grant_o[k] !== 4'b1000 || addr_o[k] !== addr_in[3*AW +: AW]) begin
            bad++;
            $display("FAIL midreset_regrant dut%0d: grant=%b addr=%h, want grant=1000 addr=%h",
                     k, grant_o[k], addr_o[k], addr_in[3*AW +: AW]);
         end
      end
      req = '0;
      for (int c = 0; c < 6; c++) begin
         tick();
         for (int k = 0; k < int'(ND); k++) begin
            total++;
            if ({grant_o[k], done_o[k], addr_o[k], we_o[k], busy_o[k]} !==
                {exp_grant(k), exp_done(k), m_addr[k], m_we[k], exp_busy(k)}) begin
               bad++;
               $display("FAIL midreset_cycle dut%0d c%0d: grant=%b done=%b addr=%h we=%b busy=%b, want %b %b %h %b %b",
                        k, c, grant_o[k], done_o[k], addr_o[k], we_o[k], busy_o[k],
                        exp_grant(k), exp_done(k), m_addr[k], m_we[k], exp_busy(k));
            end
         end
      end
   endtask

   task automatic test_withdraw();
      int n_done [ND];
      int n_regrant [ND];
      apply_reset();
      for (int k = 0; k < int'(ND); k++) begin
         n_done[k]    = 0;
         n_regrant[k] = 0;
      end
      addr_in = {$urandom, $urandom};
      we_in   = '0;
      req     = 4'b0010;
      tick();
      req = '0;
      for (int c = 0; c < 8; c++) begin
         tick();
         for (int k = 0; k < int'(ND); k++) begin
            if (done_o[k] != '0) n_done[k]++;
            if (n_done[k] > 0 && grant_o[k] != '0) n_regrant[k]++;
         end
      end
      for (int k = 0; k < int'(ND); k++) begin
         total++;
         if (n_done[k] != 1 || n_regrant[k] != 0) begin
            bad++;
            $display("FAIL withdraw dut%0d: done pulses=%0d regrants=%0d, want 1 and 0",
                     k, n_done[k], n_regrant[k]);
         end
      end
   endtask

   task automatic test_random();
      apply_reset();
      for (int c = 0; c < 500; c++) begin
         rst     = ($urandom_range(0, 59) == 0);
         req     = ($urandom_range(0, 3) == 0) ? '0 : NC'($urandom);
         addr_in = {$urandom, $urandom};
         we_in   = NC'($urandom);
         tick();
         for (int k = 0; k < int'(ND); k++) begin
            total++;
            if ({grant_o[k], done_o[k], addr_o[k], we_o[k], busy_o[k]} !==
                {exp_grant(k), exp_done(k), m_addr[k], m_we[k], exp_busy(k)}) begin
               bad++;
               $display("FAIL random_cycle dut%0d c%0d: grant=%b done=%b addr=%h we=%b busy=%b, want %b %b %h %b %b",
                        k, c, grant_o[k], done_o[k], addr_o[k], we_o[k], busy_o[k],
                        exp_grant(k), exp_done(k), m_addr[k], m_we[k], exp_busy(k));
            end
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      edge_n  = 0;
      rst     = 1'b1;
      req     = '0;
      addr_in = '0;
      we_in   = '0;
      for (int k = 0; k < int'(ND); k++) begin
         m_active[k] = 1'b0;
         m_start[k]  = 0;
         m_win[k]    = 0;
         m_ptr[k]    = NC - 1;
         m_addr[k]   = '0;
         m_we[k]     = 1'b0;
      end
      @(posedge clk);
      test_reset();
      test_idle_park();
      test_single_access();
      test_contention();
      test_reset_mid_access();
      test_withdraw();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
